// File: rtl/fp_align_if.sv
// Operand-pair / aligned-result handshake bundle for the FP adder alignment stage.
// The slave modport is the alignment pipe; the master modport is its environment.
interface fp_align_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  logic             in_valid;
  logic             in_ready;
  logic             a_sgn;
  logic             b_sgn;
  logic [EXP_W-1:0] a_exp;
  logic [EXP_W-1:0] b_exp;
  logic [MAN_W-1:0] a_man;
  logic [MAN_W-1:0] b_man;
  logic             out_valid;
  logic             out_ready;
  logic [EXP_W-1:0] out_exp;
  logic             out_big_sgn;
  logic             out_sml_sgn;
  logic [MAN_W:0]   out_big_sig;
  logic [MAN_W+3:0] out_sml_sig;
  logic [EXP_W-1:0] out_diff;
  logic             out_swap;

  modport master (
    output in_valid, a_sgn, b_sgn, a_exp, b_exp, a_man, b_man, out_ready,
    input  in_ready, out_valid, out_exp, out_big_sgn, out_sml_sgn, out_big_sig,
           out_sml_sig, out_diff, out_swap
  );

  modport slave (
    input  in_valid, a_sgn, b_sgn, a_exp, b_exp, a_man, b_man, out_ready,
    output in_ready, out_valid, out_exp, out_big_sgn, out_sml_sgn, out_big_sig,
           out_sml_sig, out_diff, out_swap
  );
endinterface

// File: rtl/fp_align_pipe.sv
// Two-stage FP adder front end: S1 compares exponents and orders operands by magnitude,
// S2 right-shifts the smaller significand keeping guard/round/sticky.
module fp_align_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input logic       clk,
  input logic       rst_n,
  fp_align_if.slave pipe_io
);
  localparam int unsigned SW = MAN_W + 4;

  logic s2_adv, s1_adv;

  // ---------------- Stage 1: compare and swap ----------------
  logic             hid_a, hid_b, borrow, swap_c;
  logic [EXP_W-1:0] ea_eff, eb_eff;
  logic [EXP_W:0]   sub;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_big_sgn_q, s1_big_sgn_d, s1_sml_sgn_q, s1_sml_sgn_d, s1_swap_q;
  logic [MAN_W:0]   s1_big_sig_q, s1_big_sig_d, s1_sml_sig_q, s1_sml_sig_d;
  logic [EXP_W-1:0] s1_exp_q, s1_exp_d, s1_diff_q, s1_diff_d;
  logic             s1_load;

  always_comb begin
    hid_a  = |pipe_io.a_exp;
    hid_b  = |pipe_io.b_exp;
    ea_eff = hid_a ? pipe_io.a_exp : EXP_W'(1);
    eb_eff = hid_b ? pipe_io.b_exp : EXP_W'(1);
    sub    = {1'b0, ea_eff} - {1'b0, eb_eff};
    borrow = sub[EXP_W];
    // Equal magnitudes keep a as the larger operand.
    swap_c = borrow || ((sub == '0) && (pipe_io.b_man > pipe_io.a_man));

    s1_diff_d    = borrow ? (eb_eff - ea_eff) : sub[EXP_W-1:0];
    s1_exp_d     = borrow ? eb_eff : ea_eff;
    s1_big_sgn_d = swap_c ? pipe_io.b_sgn : pipe_io.a_sgn;
    s1_sml_sgn_d = swap_c ? pipe_io.a_sgn : pipe_io.b_sgn;
    s1_big_sig_d = swap_c ? {hid_b, pipe_io.b_man} : {hid_a, pipe_io.a_man};
    s1_sml_sig_d = swap_c ? {hid_a, pipe_io.a_man} : {hid_b, pipe_io.b_man};
  end

  // ---------------- Handshake ----------------
  assign s2_adv           = !pipe_io.out_valid || pipe_io.out_ready;
  assign s1_adv           = !s1_valid_q || s2_adv;
  assign pipe_io.in_ready = s1_adv;
  assign s1_load          = pipe_io.in_valid && s1_adv;
  assign s1_valid_d       = s1_adv ? pipe_io.in_valid : s1_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_big_sgn_q <= 1'b0;
      s1_sml_sgn_q <= 1'b0;
      s1_swap_q    <= 1'b0;
      s1_big_sig_q <= '0;
      s1_sml_sig_q <= '0;
      s1_exp_q     <= '0;
      s1_diff_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_load) begin
        s1_big_sgn_q <= s1_big_sgn_d;
        s1_sml_sgn_q <= s1_sml_sgn_d;
        s1_swap_q    <= swap_c;
        s1_big_sig_q <= s1_big_sig_d;
        s1_sml_sig_q <= s1_sml_sig_d;
        s1_exp_q     <= s1_exp_d;
        s1_diff_q    <= s1_diff_d;
      end
    end
  end

  // ---------------- Stage 2: align ----------------
  logic [SW-1:0]    ext, ones, lost_mask, sml_sig_d;
  logic [EXP_W-1:0] sh;
  logic             sticky, s2_load, out_valid_d;

  always_comb begin
    ext  = {s1_sml_sig_q, 3'b000};
    ones = '1;
    sh   = (s1_diff_q >= EXP_W'(SW)) ? EXP_W'(SW) : s1_diff_q;
    // A shift of SW clears ones entirely, so the mask then covers every bit of ext.
    lost_mask = ~(ones << sh);
    sticky    = |(ext & lost_mask);
    sml_sig_d = (ext >> sh) | {{(SW-1){1'b0}}, sticky};
  end

  logic             out_valid_q, out_big_sgn_q, out_sml_sgn_q, out_swap_q;
  logic [EXP_W-1:0] out_exp_q, out_diff_q;
  logic [MAN_W:0]   out_big_sig_q;
  logic [SW-1:0]    out_sml_sig_q;

  assign s2_load     = s1_valid_q && s2_adv;
  assign out_valid_d = s2_adv ? s1_valid_q : out_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_big_sgn_q <= 1'b0;
      out_sml_sgn_q <= 1'b0;
      out_swap_q    <= 1'b0;
      out_exp_q     <= '0;
      out_diff_q    <= '0;
      out_big_sig_q <= '0;
      out_sml_sig_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (s2_load) begin
        out_big_sgn_q <= s1_big_sgn_q;
        out_sml_sgn_q <= s1_sml_sgn_q;
        out_swap_q    <= s1_swap_q;
        out_exp_q     <= s1_exp_q;
        out_diff_q    <= s1_diff_q;
        out_big_sig_q <= s1_big_sig_q;
        out_sml_sig_q <= sml_sig_d;
      end
    end
  end

  assign pipe_io.out_valid   = out_valid_q;
  assign pipe_io.out_exp     = out_exp_q;
  assign pipe_io.out_big_sgn = out_big_sgn_q;
  assign pipe_io.out_sml_sgn = out_sml_sgn_q;
  assign pipe_io.out_big_sig = out_big_sig_q;
  assign pipe_io.out_sml_sig = out_sml_sig_q;
  assign pipe_io.out_diff    = out_diff_q;
  assign pipe_io.out_swap    = out_swap_q;
endmodule

// File: tb/tb_fp_align_pipe.sv
// Bench for fp_align_pipe: directed cases, backpressure stream, async reset, random traffic,
// all scored against an arithmetic reference model.
module tb_fp_align_pipe;
  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;

  typedef struct packed {
    logic [7:0]  exp;
    logic        bs;
    logic        ss;
    logic [23:0] bsig;
    logic [26:0] ssig;
    logic [7:0]  diff;
    logic        sw;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   n_drained = 0;
  res_t exp_q[$];

  fp_align_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

  fp_align_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pipe_io (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] req);
    tests++;
    assert (obs === req) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, req);
    end
  endtask

  // Reference: magnitude ordering on (effective exponent, fraction), alignment by division.
  function automatic res_t model(input logic sa, input logic [7:0] ea, input logic [22:0] ma,
                                 input logic sb, input logic [7:0] eb, input logic [22:0] mb);
    res_t   r;
    int     xa, xb, d;
    longint siga, sigb, ext, q, rem, div;
    bit     bbig;
    xa   = (ea == 0) ? 1 : int'(ea);
    xb   = (eb == 0) ? 1 : int'(eb);
    siga = (ea != 0 ? 64'd8388608 : 64'd0) + longint'(ma);
    sigb = (eb != 0 ? 64'd8388608 : 64'd0) + longint'(mb);
    bbig = (xb > xa) || (xb == xa && mb > ma);
    d    = (xa > xb) ? xa - xb : xb - xa;
    r.sw   = bbig;
    r.exp  = 8'(bbig ? xb : xa);
    r.diff = 8'(d);
    r.bs   = bbig ? sb : sa;
    r.ss   = bbig ? sa : sb;
    r.bsig = 24'(bbig ? sigb : siga);
    ext    = (bbig ? siga : sigb) * 8;
    if (d >= 27) begin
      r.ssig = (ext != 0) ? 27'd1 : 27'd0;
    end else begin
      div    = longint'(1) << d;
      q      = ext / div;
      rem    = ext % div;
      q      = (rem != 0) ? (q | 1) : q;
      r.ssig = q[26:0];
    end
    return r;
  endfunction

  function automatic res_t cur_out();
    res_t r;
    r.exp  = bus.out_exp;
    r.bs   = bus.out_big_sgn;
    r.ss   = bus.out_sml_sgn;
    r.bsig = bus.out_big_sig;
    r.ssig = bus.out_sml_sig;
    r.diff = bus.out_diff;
    r.sw   = bus.out_swap;
    return r;
  endfunction

  task automatic set_in(input logic v, input logic sa, input logic [7:0] ea,
                        input logic [22:0] ma, input logic sb, input logic [7:0] eb,
                        input logic [22:0] mb);
    bus.in_valid = v;
    bus.a_sgn = sa; bus.a_exp = ea; bus.a_man = ma;
    bus.b_sgn = sb; bus.b_exp = eb; bus.b_man = mb;
  endtask

  // One clock: score drain/accept just before the edge, check hold stability just after.
  task automatic cycle(output bit acc);
    res_t held;
    bit   hold;
    #1;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) chk("drain_unexpected", 1, 0);
      else begin
        chk("drain", cur_out(), exp_q.pop_front());
        n_drained++;
      end
    end
    hold = bus.out_valid && !bus.out_ready;
    held = cur_out();
    acc  = bus.in_valid && bus.in_ready;
    if (acc) exp_q.push_back(model(bus.a_sgn, bus.a_exp, bus.a_man,
                                   bus.b_sgn, bus.b_exp, bus.b_man));
    @(posedge clk);
    #1;
    if (hold) begin
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_data", cur_out(), held);
    end
  endtask

  // Present one pair into an empty pipe; leaves its result on the outputs.
  task automatic send1(input logic sa, input logic [7:0] ea, input logic [22:0] ma,
                       input logic sb, input logic [7:0] eb, input logic [22:0] mb);
    bit acc;
    bus.out_ready = 1'b1;
    set_in(1'b1, sa, ea, ma, sb, eb, mb);
    cycle(acc);
    chk("lat_accept", acc, 1);
    chk("lat_not_yet", bus.out_valid, 0);
    set_in(1'b0, 0, 0, 0, 0, 0, 0);
    cycle(acc);
    chk("lat_valid", bus.out_valid, 1);
  endtask

  initial begin
    bit acc;
    int stalled, cyc, base;
    set_in(1'b0, 0, 0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_outputs", cur_out(), '0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1.0 + 0.25
    send1(0, 8'd127, 23'h0, 0, 8'd125, 23'h0);
    chk("t1_exp", bus.out_exp, 127);
    chk("t1_diff", bus.out_diff, 2);
    chk("t1_swap", bus.out_swap, 0);
    chk("t1_big", bus.out_big_sig, 24'h800000);
    chk("t1_sml", bus.out_sml_sig, 27'h1000000);
    cycle(acc);

    // 0.05 + 1.23
    send1(0, 8'd122, 23'h4CCCCD, 1, 8'd127, 23'h1D70A4);
    chk("t2_swap", bus.out_swap, 1);
    chk("t2_diff", bus.out_diff, 5);
    chk("t2_exp", bus.out_exp, 127);
    chk("t2_sgn", {bus.out_big_sgn, bus.out_sml_sgn}, 2'b10);
    chk("t2_big", bus.out_big_sig, 24'h9D70A4);
    chk("t2_sml", bus.out_sml_sig, 27'h0333333);
    cycle(acc);

    // Equal exponents, b fraction larger
    send1(0, 8'd127, 23'h100, 0, 8'd127, 23'h200);
    chk("t3_swap", bus.out_swap, 1);
    chk("t3_diff", bus.out_diff, 0);
    chk("t3_sml", bus.out_sml_sig, 27'h4000800);
    cycle(acc);

    // Exact tie keeps a as larger
    send1(0, 8'd100, 23'h1234, 1, 8'd100, 23'h1234);
    chk("tie_swap", bus.out_swap, 0);
    cycle(acc);

    // 20.1 + 0.001, then a 40-step gap that leaves only sticky
    send1(0, 8'd131, 23'h20CCCD, 0, 8'd117, 23'h03126F);
    chk("t4_diff", bus.out_diff, 14);
    cycle(acc);
    send1(0, 8'd160, 23'h0, 0, 8'd120, 23'h0);
    chk("t4_sticky", bus.out_sml_sig, 27'h0000001);
    cycle(acc);

    // Denormal a: effective exponent 1, hidden 0
    send1(0, 8'd0, 23'h400000, 0, 8'd2, 23'h0);
    chk("den_diff", bus.out_diff, 1);
    chk("den_swap", bus.out_swap, 1);
    chk("den_sml", bus.out_sml_sig, 27'h1000000);
    cycle(acc);

    // Shift saturation boundary at 27
    send1(0, 8'd30, 23'h0, 0, 8'd3, 23'h0);
    chk("sat27_sml", bus.out_sml_sig, 27'h0000001);
    cycle(acc);

    // Five back-to-back pairs with out_ready low for cycles 3-5
    base = n_drained;
    stalled = 0;
    cyc = 0;
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, i[0], 8'(100 + 3 * i), 23'(i * 77777), 1'b0, 8'(102 + i), 23'(i * 5));
      acc = 0;
      for (int t = 0; t < 20 && !acc; t++) begin
        bus.out_ready = !(cyc >= 3 && cyc <= 5);
        cycle(acc);
        if (!acc) stalled++;
        cyc++;
      end
      if (!acc) chk("stream_timeout", 0, 1);
    end
    set_in(1'b0, 0, 0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    for (int t = 0; t < 20 && (exp_q.size() != 0 || bus.out_valid); t++) cycle(acc);
    chk("stream_in_ready_drop", stalled > 0, 1);
    chk("stream_count", n_drained - base, 5);
    chk("stream_empty", exp_q.size(), 0);

    // Async reset with two pairs in flight
    bus.out_ready = 1'b0;
    set_in(1'b1, 0, 8'd90, 23'h1, 0, 8'd91, 23'h2);
    cycle(acc);
    set_in(1'b1, 1, 8'd80, 23'h3, 0, 8'd70, 23'h4);
    cycle(acc);
    set_in(1'b0, 0, 0, 0, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_outputs", cur_out(), '0);
    chk("arst_in_ready", bus.in_ready, 1);
    exp_q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send1(0, 8'd127, 23'h0, 0, 8'd125, 23'h0);
    chk("arst_after_sml", bus.out_sml_sig, 27'h1000000);
    cycle(acc);

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      logic [7:0] ea, eb;
      ea = ($urandom % 8 == 0) ? 8'd0 : 8'($urandom);
      case ($urandom % 4)
        0:       eb = ea;
        1:       eb = 8'(ea + $urandom_range(0, 30));
        2:       eb = 8'(ea - $urandom_range(0, 30));
        default: eb = 8'($urandom);
      endcase
      set_in($urandom % 4 != 0, 1'($urandom), ea, 23'($urandom), 1'($urandom), eb,
             ($urandom % 6 == 0) ? 23'h7 : 23'($urandom));
      bus.out_ready = ($urandom % 4 != 0);
      cycle(acc);
    end
    set_in(1'b0, 0, 0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    for (int t = 0; t < 20 && (exp_q.size() != 0 || bus.out_valid); t++) cycle(acc);
    chk("rand_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
